ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. Sends command bytes (e.g. 0xED set-LEDs, 0xF4 enable) to the keyboard, the reverse direction of the existing keyboard receive path. It drives the open-drain PS2_CLK/PS2_DATA lines through active-high pull-low enables and runs the full request-to-send, clocked-bit, and ACK sequence. It reports completion or error to the command logic.

Parameters:
INHIBIT_CYCLES, 5000, CLK cycles PS2_CLK is held low before the start bit (100 us at 50 MHz)
TIMEOUT_CYCLES, 750000, max CLK cycles between device clock falling edges, or from release to first edge (15 ms)
SYNC_STAGES, 2, synchronizer depth on PS2_CLK_IN/PS2_DATA_IN (min 2)

Ports:
CLK  input  1  board clock
RST_N  input  1  asynchronous active-low reset
TX_DATA  input  8  command byte
TX_VALID  input  1  request; the byte is accepted when TX_VALID && TX_READY
TX_READY  output  1  high in IDLE only
TX_DONE  output  1  1-cycle pulse: frame sent and device ACK seen
TX_ERR  output  1  1-cycle pulse: no ACK or timeout
BUSY  output  1  high in any state except IDLE
PS2_CLK_IN  input  1  sensed keyboard clock line
PS2_DATA_IN  input  1  sensed keyboard data line
PS2_CLK_OE  output  1  1 = pull PS2_CLK low, 0 = release
PS2_DATA_OE  output  1  1 = pull PS2_DATA low, 0 = release

Behaviour:
- Reset (async, immediate): state IDLE; PS2_CLK_OE=0, PS2_DATA_OE=0, TX_DONE=0, TX_ERR=0, BUSY=0, TX_READY=1; all counters 0; synchronizers preset to 1.
- Inputs pass through a SYNC_STAGES flop chain. falling_edge = previous synced clock 1 and current 0, evaluated every CLK cycle.
- Accept: latch TX_DATA into shift_reg[7:0]. Compute parity = ~^TX_DATA (odd parity). Set bit_cnt=0 and go to INHIBIT on the next edge. TX_VALID while busy is ignored.
- INHIBIT: PS2_CLK_OE=1 and PS2_DATA_OE=0 for exactly INHIBIT_CYCLES cycles. Then PS2_DATA_OE=1 (start bit), and one cycle later PS2_CLK_OE=0. Go to START.
- START: hold PS2_DATA_OE=1 and wait for falling_edge. On that edge, drive data bit 0 (PS2_DATA_OE = ~bit), bit_cnt=1, go to DATA.
- DATA: on each falling_edge, drive the next bit LSB first. When bit_cnt reaches 8, the falling edge drives parity and the state goes to PARITY.
- PARITY: next falling_edge sets PS2_DATA_OE=0 (stop bit, released line) and goes to ACK.
- ACK: next falling_edge samples synced PS2_DATA_IN. If 0, go to WAIT_IDLE. If 1, pulse TX_ERR and go to IDLE.
- WAIT_IDLE: when synced clock and data are both 1, pulse TX_DONE and go to IDLE.
- Timeout: a counter clears on every falling_edge and on entry to START. In START, DATA, PARITY, ACK and WAIT_IDLE, reaching TIMEOUT_CYCLES releases both lines in the same cycle, pulses TX_ERR, and returns to IDLE.
- Both OEs are 0 in every IDLE cycle. TX_DONE and TX_ERR are mutually exclusive and never asserted in consecutive frames without a return to IDLE.
- Output latency: TX_DONE/TX_ERR are registered, asserted one cycle after the deciding event.
- A reset during any state releases both lines asynchronously, and the frame is abandoned.

Optional Feature:
PS2_TX_RETRY_EN. When defined, a NACK or timeout re-enters INHIBIT with the latched byte, up to 2 retries. TX_ERR pulses only after the 3rd failed attempt, and BUSY stays high across retries. When undefined, the first failure pulses TX_ERR and returns to IDLE.

Test Plan:
- Send 0xED; the device model clocks at 12.5 kHz and ACKs. Required: PS2_CLK_OE high for exactly 5000 cycles. The bits sampled by the model on rising edges are 0,1,0,1,1,0,1,1,1, then parity=1, then stop=1. TX_DONE pulses once, and BUSY/TX_READY return to 0/1.
- Send 0xF4 with ACK. Required: data bits 0,0,1,0,1,1,1,1, parity=0, then TX_DONE.
- Send 0x55 with the model leaving DATA high on the 11th clock. Required: TX_ERR pulses, TX_DONE stays 0, both OEs are 0.
- Send 0xFF and the model never clocks. Required: TX_ERR pulses TIMEOUT_CYCLES+1 cycles after PS2_CLK_OE deasserts, and the lines are released. With PS2_TX_RETRY_EN, the sequence is 3 inhibit pulses and then TX_ERR.
- Assert RST_N=0 mid-DATA (after bit 4). Required: both OEs drop to 0 within the same cycle and the state is IDLE. A following 0xF4 transfer completes normally.
- Hold TX_VALID with a new byte throughout a frame. Required: only one byte is accepted per frame, and the second is accepted on the first IDLE cycle after TX_DONE.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter.
// Sequence: inhibit the clock, send the start bit, 8 data bits LSB first and
// odd parity on device clock falling edges, release for stop, then check the
// device ACK. Lines are driven through active-high pull-low enables.
// Optional macro PS2_TX_RETRY_EN: a NACK or timeout re-sends the latched byte
// up to twice before TX_ERR is raised.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic       TX_DONE,
  output logic       TX_ERR,
  output logic       BUSY,
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DATA_IN,
  output logic       PS2_CLK_OE,
  output logic       PS2_DATA_OE
);

  localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int unsigned INH_W  = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES);
  localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_DATA, S_PARITY, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t              state_q, state_d;
  logic [SYNC_N-1:0]   clk_sync_q, clk_sync_d;
  logic [SYNC_N-1:0]   data_sync_q, data_sync_d;
  logic                clk_prev_q, clk_prev_d;
  logic [7:0]          byte_q, byte_d;
  logic                parity_q, parity_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [INH_W-1:0]    inh_cnt_q, inh_cnt_d;
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic                clk_oe_q, clk_oe_d;
  logic                data_oe_q, data_oe_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                ready_q, ready_d;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]          retry_q, retry_d;
`endif

  logic clk_s_c;
  logic data_s_c;
  logic falling_edge_c;
  logic fail_c;

  assign clk_s_c        = clk_sync_q[SYNC_N-1];
  assign data_s_c       = data_sync_q[SYNC_N-1];
  assign falling_edge_c = clk_prev_q & ~clk_s_c;

  assign TX_READY    = ready_q;
  assign TX_DONE     = done_q;
  assign TX_ERR      = err_q;
  assign BUSY        = busy_q;
  assign PS2_CLK_OE  = clk_oe_q;
  assign PS2_DATA_OE = data_oe_q;

  // Shift the sensed lines through the synchronizer chain; remember last clock.
  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_N-2:0], PS2_CLK_IN};
    data_sync_d = {data_sync_q[SYNC_N-2:0], PS2_DATA_IN};
    clk_prev_d  = clk_s_c;
  end

  // Next-state, counters and registered-output values for the frame sequencer.
  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    parity_d  = parity_q;
    bit_cnt_d = bit_cnt_q;
    inh_cnt_d = inh_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    fail_c    = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_d   = retry_q;
`endif

    case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (TX_VALID) begin
          byte_d    = TX_DATA;
          parity_d  = ~^TX_DATA;
          bit_cnt_d = 4'd0;
          inh_cnt_d = '0;
          clk_oe_d  = 1'b1;
          state_d   = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_d   = 2'd0;
`endif
        end
      end

      S_INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          // Start bit already on the line; now hand the clock to the device.
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          tmo_cnt_d = '0;
          state_d   = S_START;
        end else begin
          inh_cnt_d = inh_cnt_q + INH_W'(1);
          clk_oe_d  = 1'b1;
          data_oe_d = (inh_cnt_q == INH_PRE);
        end
      end

      S_START, S_DATA, S_PARITY, S_ACK, S_WAIT_IDLE: begin
        tmo_cnt_d = falling_edge_c ? '0 : tmo_cnt_q + TMO_W'(1);
        if (state_q == S_WAIT_IDLE && clk_s_c && data_s_c) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end else if (falling_edge_c) begin
          case (state_q)
            S_START: begin
              data_oe_d = ~byte_q[0];
              bit_cnt_d = 4'd1;
              state_d   = S_DATA;
            end
            S_DATA: begin
              if (bit_cnt_q == 4'd8) begin
                data_oe_d = ~parity_q;
                state_d   = S_PARITY;
              end else begin
                data_oe_d = ~byte_q[bit_cnt_q[2:0]];
                bit_cnt_d = bit_cnt_q + 4'd1;
              end
            end
            S_PARITY: begin
              data_oe_d = 1'b0;
              state_d   = S_ACK;
            end
            S_ACK: begin
              if (!data_s_c) state_d = S_WAIT_IDLE;
              else           fail_c  = 1'b1;
            end
            default: ;
          endcase
        end else if (tmo_cnt_q == TMO_MAX) begin
          fail_c = 1'b1;
        end
      end

      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

    // NACK or timeout: release the lines and report, or retry if enabled.
    if (fail_c) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      err_d     = 1'b1;
      state_d   = S_IDLE;
`ifdef PS2_TX_RETRY_EN
      if (retry_q != 2'd2) begin
        retry_d   = retry_q + 2'd1;
        err_d     = 1'b0;
        clk_oe_d  = 1'b1;
        inh_cnt_d = '0;
        bit_cnt_d = 4'd0;
        state_d   = S_INHIBIT;
      end
`endif
    end

    ready_d = (state_d == S_IDLE);
    busy_d  = ~ready_d;
  end

  // Synchronizer and edge-detect flops, preset to the idle-high line level.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
    end
  end

  // Sequencer state, counters and registered outputs; reset releases both lines.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      byte_q    <= '0;
      parity_q  <= 1'b0;
      bit_cnt_q <= '0;
      inh_cnt_q <= '0;
      tmo_cnt_q <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
`ifdef PS2_TX_RETRY_EN
      retry_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      parity_q  <= parity_d;
      bit_cnt_q <= bit_cnt_d;
      inh_cnt_q <= inh_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
`ifdef PS2_TX_RETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a device model clocks the bus and records the bits
// it samples; expected frames and outcomes are queued at stimulus time and a
// monitor pops and checks them on every TX_DONE/TX_ERR pulse.
module tb_ps2_host_tx;

  localparam int unsigned INH  = 5000;
  localparam int unsigned TMO  = 3000;
  localparam int          HALF = 20;   // device clock half period (scaled down)
  localparam int M_ACK = 0, M_NACK = 1, M_SILENT = 2;
`ifdef PS2_TX_RETRY_EN
  localparam int EXP_PULSES = 3;
`else
  localparam int EXP_PULSES = 1;
`endif

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [7:0] TX_DATA = 8'h00;
  logic       TX_VALID = 1'b0;
  logic       TX_READY, TX_DONE, TX_ERR, BUSY, PS2_CLK_OE, PS2_DATA_OE;
  logic       dev_clk_pull = 1'b0, dev_data_pull = 1'b0;
  logic       clk_line, data_line;

  assign clk_line  = ~PS2_CLK_OE & ~dev_clk_pull;
  assign data_line = ~PS2_DATA_OE & ~dev_data_pull;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
    .TX_READY(TX_READY), .TX_DONE(TX_DONE), .TX_ERR(TX_ERR), .BUSY(BUSY),
    .PS2_CLK_IN(clk_line), .PS2_DATA_IN(data_line),
    .PS2_CLK_OE(PS2_CLK_OE), .PS2_DATA_OE(PS2_DATA_OE)
  );

  always #10 CLK = ~CLK;

  typedef struct {
    logic        ok;
    int          nbits;
    logic [10:0] frame;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int total = 0, bad = 0;
  int cyc = 0, resp_cnt = 0, err_cyc = 0, oe_fall_cyc = 0;
  int inh_lo = 0, inh_ov = 0, inh_pulses = 0;
  int acc_cnt = 0;
  logic acc_done = 1'b0;
  logic clk_oe_prev = 1'b0;
  int dev_mode = M_ACK;
  logic dev_armed = 1'b0, dev_busy = 1'b0;
  logic [10:0] cap_bits = '0;
  int cap_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  always @(posedge CLK) cyc++;

  // Device model: on a request-to-send, generate 11 clocks, sampling the data
  // line while the clock is high, and optionally pull data low as the ACK.
  initial begin
    forever begin
      @(negedge CLK);
      if (dev_armed && clk_line && !data_line) begin
        dev_busy = 1'b1;
        if (dev_mode == M_ACK) dev_armed = 1'b0;
        cap_n = 0;
        cap_bits = '0;
        repeat (HALF) @(negedge CLK);
        for (int i = 0; i < 11; i++) begin
          cap_bits[i] = data_line;
          cap_n++;
          if (i == 10 && dev_mode == M_ACK) dev_data_pull = 1'b1;
          dev_clk_pull = 1'b1;
          repeat (HALF) @(negedge CLK);
          dev_clk_pull = 1'b0;
          repeat (HALF) @(negedge CLK);
        end
        dev_data_pull = 1'b0;
        dev_busy = 1'b0;
      end
    end
  end

  // Scoreboard monitor: pop the queued expectation on each completion pulse.
  always @(negedge CLK) begin
    exp_t  e;
    string n;
    chk("done_err_excl", 32'(TX_DONE & TX_ERR), 32'd0);
    if (TX_READY) chk("idle_oe", 32'({PS2_CLK_OE, PS2_DATA_OE}), 32'd0);
    if (TX_DONE || TX_ERR) begin
      resp_cnt++;
      err_cyc = cyc;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got done=%0d err=%0d want none", TX_DONE, TX_ERR);
      end else begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        chk({n, "_outcome_done"}, 32'(TX_DONE), 32'(e.ok));
        if (e.nbits > 0) begin
          chk({n, "_nbits"}, 32'(cap_n), 32'(e.nbits));
          chk({n, "_frame"}, 32'(cap_bits), 32'(e.frame));
        end
      end
    end
  end

  // Inhibit monitor: clock-low time before the start bit, and the overlap cycle.
  always @(negedge CLK) begin
    if (PS2_CLK_OE && !PS2_DATA_OE) inh_lo++;
    if (PS2_CLK_OE && PS2_DATA_OE)  inh_ov++;
    if (clk_oe_prev && !PS2_CLK_OE) begin
      chk("inhibit_len", 32'(inh_lo), 32'(INH));
      chk("inhibit_overlap", 32'(inh_ov), 32'd1);
      inh_lo = 0;
      inh_ov = 0;
      inh_pulses++;
      oe_fall_cyc = cyc;
    end
    clk_oe_prev = PS2_CLK_OE;
  end

  // Handshake monitor: log each accept and whether TX_DONE was high then.
  always @(negedge CLK) begin
    if (TX_VALID && TX_READY) begin
      acc_cnt++;
      acc_done = TX_DONE;
    end
  end

  task automatic push_exp(input string name, input logic ok, input int nbits, input logic [10:0] frame);
    exp_t e;
    e.ok = ok;
    e.nbits = nbits;
    e.frame = frame;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic wait_resp(input string name, input int r0, input int budget);
    int n = 0;
    while (resp_cnt == r0 && n < budget) begin step(); n++; end
    chk({name, "_resp_seen"}, 32'(resp_cnt != r0), 32'd1);
  endtask

  task automatic wait_model_idle(input string name);
    int n = 0;
    while (dev_busy && n < 2000) begin step(); n++; end
    chk({name, "_model_idle"}, 32'(dev_busy), 32'd0);
  endtask

  task automatic send(input string name, input logic [7:0] b, input int mode,
                      input logic ok, input int nbits, input logic [10:0] frame);
    int r0;
    int n = 0;
    push_exp(name, ok, nbits, frame);
    dev_mode = mode;
    dev_armed = (mode != M_SILENT);
    r0 = resp_cnt;
    TX_DATA = b;
    TX_VALID = 1'b1;
    while (!TX_READY && n < 100) begin step(); n++; end
    step();
    TX_VALID = 1'b0;
    wait_resp(name, r0, 40000);
    chk({name, "_ready"}, 32'(TX_READY), 32'd1);
    chk({name, "_busy"}, 32'(BUSY), 32'd0);
    chk({name, "_oes"}, 32'({PS2_CLK_OE, PS2_DATA_OE}), 32'd0);
    wait_model_idle(name);
  endtask

  initial begin
    int n;
    int r0;
    int p0;
    int a0;

    // Reset state
    @(posedge CLK);
    #1;
    chk("rst_ready", 32'(TX_READY), 32'd1);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done_err", 32'({TX_DONE, TX_ERR}), 32'd0);
    chk("rst_oes", 32'({PS2_CLK_OE, PS2_DATA_OE}), 32'd0);
    repeat (3) step();
    RST_N = 1'b1;
    step();

    // Frames as the device samples them: {stop, parity, data[7:0], start}
    send("ed_ack", 8'hED, M_ACK, 1'b1, 11, 11'b1_1_11101101_0);
    send("f4_ack", 8'hF4, M_ACK, 1'b1, 11, 11'b1_0_11110100_0);
    send("55_nack", 8'h55, M_NACK, 1'b0, 11, 11'b1_1_01010101_0);

    // No device clock at all: error after the timeout, lines released
    p0 = inh_pulses;
    send("ff_tmo", 8'hFF, M_SILENT, 1'b0, 0, 11'd0);
    chk("tmo_latency", 32'(err_cyc - oe_fall_cyc), 32'(TMO + 1));
    chk("tmo_inhibit_pulses", 32'(inh_pulses - p0), 32'(EXP_PULSES));

    // Reset in the middle of the data bits
    r0 = resp_cnt;
    dev_mode = M_ACK;
    dev_armed = 1'b1;
    TX_DATA = 8'hF4;
    TX_VALID = 1'b1;
    step();
    TX_VALID = 1'b0;
    n = 0;
    while (!dev_busy && n < 8000) begin step(); n++; end
    chk("mid_model_started", 32'(dev_busy), 32'd1);
    n = 0;
    while (cap_n < 6 && n < 2000) begin step(); n++; end
    chk("mid_reached_bit4", 32'(cap_n >= 6), 32'd1);
    chk("mid_busy_before_rst", 32'(BUSY), 32'd1);
    RST_N = 1'b0;
    #1;
    chk("mid_rst_oes", 32'({PS2_CLK_OE, PS2_DATA_OE}), 32'd0);
    chk("mid_rst_ready", 32'(TX_READY), 32'd1);
    chk("mid_rst_busy", 32'(BUSY), 32'd0);
    repeat (3) step();
    RST_N = 1'b1;
    wait_model_idle("mid_rst");
    chk("mid_rst_no_resp", 32'(resp_cnt - r0), 32'd0);
    send("f4_after_rst", 8'hF4, M_ACK, 1'b1, 11, 11'b1_0_11110100_0);

    // TX_VALID held across a frame with the next byte waiting
    push_exp("hold_a", 1'b1, 11, 11'b1_1_00010010_0);
    push_exp("hold_b", 1'b1, 11, 11'b1_0_10000000_0);
    dev_mode = M_ACK;
    dev_armed = 1'b1;
    a0 = acc_cnt;
    r0 = resp_cnt;
    TX_DATA = 8'h12;
    TX_VALID = 1'b1;
    step();
    TX_DATA = 8'h80;
    wait_resp("hold_a", r0, 20000);
    dev_armed = 1'b1;
    chk("hold_accepts", 32'(acc_cnt - a0), 32'd2);
    chk("hold_b_on_done_cycle", 32'(acc_done), 32'd1);
    step();
    TX_VALID = 1'b0;
    wait_resp("hold_b", r0 + 1, 20000);
    chk("hold_b_ready", 32'(TX_READY), 32'd1);
    chk("hold_b_busy", 32'(BUSY), 32'd0);
    wait_model_idle("hold_b");
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
